aes_dec_word_loader: RTL and testbench

AES_DEC_WORD_LOADER -- requirements
Module: aes_dec_word_loader

---
 rtl/aes_dec_word_loader.sv | 141 ++++++++++++++
 tb/tb_aes_dec_word_loader.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_dec_word_loader.sv
// Word-serial front end for a 128-bit AES decryption core.
// Collects an optional 4-word key and a 4-word ciphertext block, most significant word first.
// Holds both stable for the core, then captures the plaintext a fixed LATENCY cycles later.
// Streams the plaintext back out as four 32-bit words with valid/ready handshaking.
module aes_dec_word_loader #(
    parameter int LATENCY = 40
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_word,
    input  logic         new_key,
    output logic [0:127] encrypted_data,
    output logic [0:127] cipher_key,
    input  logic [0:127] original_decrypted_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_word,
    output logic         out_last,
    output logic         busy
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD_KEY,
        ST_LOAD_DATA,
        ST_WAIT,
        ST_OUTPUT
    } state_t;

    // The counter starts at LATENCY-1 so that the capture lands exactly LATENCY edges after the last data word.
    localparam logic [7:0] WAIT_LOAD = 8'(LATENCY - 1);

    state_t         state_reg;
    logic [1:0]     idx_reg;
    logic [7:0]     wait_cnt_reg;
    logic [1:0]     k_reg;
    logic [0:127]   key_reg;
    logic [0:127]   data_reg;
    logic [0:127]   result_reg;

    logic           accept;
    logic [6:0]     word_base;
    logic [31:0]    result_word [4];

    assign accept    = in_valid && in_ready;
    assign word_base = {idx_reg, 5'b0_0000};

    // Split the captured plaintext into its four output words; word 0 holds bits [0:31].
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_result_word
            assign result_word[gi] = result_reg[32*gi +: 32];
        end
    endgenerate

    // Main control FSM, together with the key, ciphertext and result registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= ST_IDLE;
            idx_reg      <= 2'd0;
            wait_cnt_reg <= 8'd0;
            k_reg        <= 2'd0;
            key_reg      <= '0;
            data_reg     <= '0;
            result_reg   <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        // The first word of a transfer decides whether a key precedes the data.
                        if (new_key) begin
                            key_reg[0:31] <= in_word;
                            state_reg     <= ST_LOAD_KEY;
                        end else begin
                            data_reg[0:31] <= in_word;
                            state_reg      <= ST_LOAD_DATA;
                        end
                        idx_reg <= 2'd1;
                    end
                end
                ST_LOAD_KEY: begin
                    if (accept) begin
                        key_reg[word_base +: 32] <= in_word;
                        if (idx_reg == 2'd3) begin
                            idx_reg   <= 2'd0;
                            state_reg <= ST_LOAD_DATA;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end
                end
                ST_LOAD_DATA: begin
                    if (accept) begin
                        data_reg[word_base +: 32] <= in_word;
                        if (idx_reg == 2'd3) begin
                            idx_reg      <= 2'd0;
                            wait_cnt_reg <= WAIT_LOAD;
                            state_reg    <= ST_WAIT;
                        end else begin
                            idx_reg <= idx_reg + 2'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt_reg == 8'd0) begin
                        result_reg <= original_decrypted_data;
                        k_reg      <= 2'd0;
                        state_reg  <= ST_OUTPUT;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg - 8'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (out_ready) begin
                        if (k_reg == 2'd3) begin
                            k_reg     <= 2'd0;
                            state_reg <= ST_IDLE;
                        end else begin
                            k_reg <= k_reg + 2'd1;
                        end
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    // in_ready also drops while reset is held, so a word is never taken during reset.
    assign in_ready = !rst && ((state_reg == ST_IDLE) ||
                               (state_reg == ST_LOAD_KEY) ||
                               (state_reg == ST_LOAD_DATA));

    assign out_valid      = (state_reg == ST_OUTPUT);
    assign out_last       = out_valid && (k_reg == 2'd3);
    assign out_word       = out_valid ? result_word[k_reg] : 32'd0;
    assign busy           = (state_reg != ST_IDLE);
    assign encrypted_data = data_reg;
    assign cipher_key     = key_reg;

endmodule

// File: tb/tb_aes_dec_word_loader.sv
// Directed bench for aes_dec_word_loader, built around the FIPS-197 AES-128 example vector.
// The bench stands in for the decryption core.
// Its plaintext is valid only in the single cycle before the required capture edge, so capturing early or late corrupts the output.
module tb_aes_dec_word_loader;

    localparam int LAT = 5;

    localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] ZKEY_PT  = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
    localparam logic [127:0] OTHER_PT = 128'h5555aaaa5555aaaa5555aaaa5555aaaa;
    localparam logic [127:0] POISON   = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [31:0]  in_word;
    logic         new_key;
    logic [127:0] encrypted_data;
    logic [127:0] cipher_key;
    logic [127:0] original_decrypted_data;
    logic         out_valid;
    logic         out_ready;
    logic [31:0]  out_word;
    logic         out_last;
    logic         busy;

    logic         last_flag;
    int           core_cnt = -1;
    int           n_vec = 0;
    int           n_err = 0;

    aes_dec_word_loader #(.LATENCY(LAT)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .in_valid                (in_valid),
        .in_ready                (in_ready),
        .in_word                 (in_word),
        .new_key                 (new_key),
        .encrypted_data          (encrypted_data),
        .cipher_key              (cipher_key),
        .original_decrypted_data (original_decrypted_data),
        .out_valid               (out_valid),
        .out_ready               (out_ready),
        .out_word                (out_word),
        .out_last                (out_last),
        .busy                    (busy)
    );

    always #5 clk = ~clk;

    // Core stand-in: count the edges that follow acceptance of the last ciphertext word.
    always @(posedge clk) begin
        if (rst)
            core_cnt <= -1;
        else if (in_valid && in_ready && last_flag)
            core_cnt <= 0;
        else if (core_cnt >= 0)
            core_cnt <= core_cnt + 1;
    end

    // The plaintext is presented only in the cycle that precedes the LAT-th edge.
    always_comb begin
        original_decrypted_data = POISON;
        if (core_cnt == LAT - 1) begin
            if (cipher_key == FIPS_KEY && encrypted_data == FIPS_CT)
                original_decrypted_data = FIPS_PT;
            else if (cipher_key == 128'd0 && encrypted_data == FIPS_CT)
                original_decrypted_data = ZKEY_PT;
            else
                original_decrypted_data = OTHER_PT;
        end
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-22s observed %h expected %h", tag, obs, exp);
    endtask

    // Present one word starting at a negedge.
    // The task returns at the negedge after the edge that accepted the word.
    task automatic send_word(input logic [31:0] w, input logic nk, input logic lst);
        int t;
        t = 0;
        in_word   = w;
        new_key   = nk;
        in_valid  = 1'b1;
        last_flag = lst;
        while (!in_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("in_ready timeout", {127'd0, in_ready}, 128'd1);
        @(negedge clk);
        in_valid  = 1'b0;
        last_flag = 1'b0;
    endtask

    // Send n words of the FIPS stream.
    // When with_key is 1 the stream is the key followed by the ciphertext; otherwise it is the ciphertext only.
    task automatic send_block(input bit with_key, input logic nk_rest, input int gap, input int n);
        logic [127:0] kv;
        logic [127:0] cv;
        logic [31:0]  w;
        int           i;
        kv = FIPS_KEY;
        cv = FIPS_CT;
        for (int j = 0; j < n; j++) begin
            i = with_key ? j : j + 4;
            w = (i < 4) ? kv[127 - 32*i -: 32] : cv[127 - 32*(i-4) -: 32];
            send_word(w, (j == 0) ? logic'(with_key) : nk_rest, logic'(i == 7));
            repeat (gap) @(negedge clk);
        end
    endtask

    // Collect four plaintext words.
    // Before accepting each word, hold out_ready low for 'hold' cycles and check that the word stays put.
    task automatic recv_block(input logic [127:0] exp, input int hold, input string tag);
        logic [127:0] e;
        int           t;
        e = exp;
        for (int k = 0; k < 4; k++) begin
            t = 0;
            while (!out_valid && t < 200) begin
                @(negedge clk);
                t++;
            end
            check($sformatf("%s valid%0d", tag, k), {127'd0, out_valid}, 128'd1);
            for (int h = 0; h < hold; h++) begin
                check($sformatf("%s held%0d", tag, k), {96'd0, out_word}, {96'd0, e[127 - 32*k -: 32]});
                @(negedge clk);
            end
            check($sformatf("%s word%0d", tag, k), {96'd0, out_word}, {96'd0, e[127 - 32*k -: 32]});
            check($sformatf("%s last%0d", tag, k), {127'd0, out_last}, {127'd0, logic'(k == 3)});
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
        end
        check({tag, " done valid"}, {127'd0, out_valid}, 128'd0);
        check({tag, " done busy"}, {127'd0, busy}, 128'd0);
        check({tag, " done in_ready"}, {127'd0, in_ready}, 128'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_word   = 32'd0;
        new_key   = 1'b0;
        out_ready = 1'b0;
        last_flag = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state, both while reset is held and just after it is released.
        check("rst in_ready", {127'd0, in_ready}, 128'd0);
        rst = 1'b0;
        #1;
        check("rst in_ready after", {127'd0, in_ready}, 128'd1);
        check("rst busy", {127'd0, busy}, 128'd0);
        check("rst out_valid", {127'd0, out_valid}, 128'd0);
        check("rst out_last", {127'd0, out_last}, 128'd0);
        check("rst out_word", {96'd0, out_word}, 128'd0);
        check("rst key", cipher_key, 128'd0);
        check("rst data", encrypted_data, 128'd0);
        @(negedge clk);

        // FIPS-197 vector with a new key.
        // After the last word, in_valid stays high through WAIT and into OUTPUT.
        send_block(1'b1, 1'b0, 0, 8);
        check("fips key", cipher_key, FIPS_KEY);
        check("fips ct", encrypted_data, FIPS_CT);
        check("fips busy", {127'd0, busy}, 128'd1);
        in_valid = 1'b1;
        in_word  = 32'hffffffff;
        new_key  = 1'b1;
        for (int c = 0; c < LAT + 2; c++) begin
            check($sformatf("hold in_ready c%0d", c), {127'd0, in_ready}, 128'd0);
            check($sformatf("hold ct c%0d", c), encrypted_data, FIPS_CT);
            @(negedge clk);
        end
        in_valid = 1'b0;
        recv_block(FIPS_PT, 0, "fips");

        // Reuse the held key: send only the ciphertext, and apply output backpressure.
        send_block(1'b0, 1'b0, 0, 4);
        check("reuse key", cipher_key, FIPS_KEY);
        recv_block(FIPS_PT, 2, "reuse");

        // Leave gaps in in_valid during the load.
        // new_key is high on every later word and must be ignored.
        send_block(1'b1, 1'b1, 2, 8);
        check("gap key", cipher_key, FIPS_KEY);
        recv_block(FIPS_PT, 1, "gap");

        // Reset after five accepted words aborts the transfer.
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_block(1'b1, 1'b0, 0, 5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort busy", {127'd0, busy}, 128'd0);
        check("abort key", cipher_key, 128'd0);
        check("abort data", encrypted_data, 128'd0);
        check("abort out_valid", {127'd0, out_valid}, 128'd0);
        check("abort in_ready", {127'd0, in_ready}, 128'd1);
        @(negedge clk);

        // new_key=0 straight after reset: the core sees an all-zero key.
        send_block(1'b0, 1'b0, 0, 4);
        check("zkey key", cipher_key, 128'd0);
        recv_block(ZKEY_PT, 0, "zkey");

        // A full 8-word transfer after the abort decrypts correctly.
        send_block(1'b1, 1'b0, 0, 8);
        recv_block(FIPS_PT, 0, "post");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
